// File: rtl/signal_monitor_pkg.sv
// Shared lamp/fault encodings, FSM states and helpers for the signal conflict monitor.
package signal_monitor_pkg;

    localparam int unsigned LAMP_W = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CODE_W = 3;

    // Lamp encoding: bit2 = red, bit1 = yellow, bit0 = green
    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

    localparam logic [CODE_W-1:0] FC_NONE      = 3'd0;
    localparam logic [CODE_W-1:0] FC_CONFLICT  = 3'd1;
    localparam logic [CODE_W-1:0] FC_INVALID   = 3'd2;
    localparam logic [CODE_W-1:0] FC_WALK      = 3'd3;
    localparam logic [CODE_W-1:0] FC_SHORT_YEL = 3'd4;

    localparam int unsigned DEF_FAULT_FILTER   = 2;
    localparam int unsigned DEF_MIN_YELLOW     = 2;
    localparam int unsigned DEF_FLASH_HALF     = 1;
    localparam int unsigned DEF_STARTUP_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    typedef struct packed {
        logic [LAMP_W-1:0] t1_lamp;
        logic [LAMP_W-1:0] t2_lamp;
        logic              t1_walk;
        logic              t2_walk;
    } lamp_drive_t;

    function automatic logic lamp_legal(input logic [LAMP_W-1:0] code);
        return (code == LAMP_RED) || (code == LAMP_YEL) || (code == LAMP_GRN);
    endfunction

    // Both heads red (or dark) with walks off, used while flashing
    function automatic lamp_drive_t flash_drive(input logic on);
        lamp_drive_t d;
        d.t1_lamp = on ? LAMP_RED : LAMP_OFF;
        d.t2_lamp = on ? LAMP_RED : LAMP_OFF;
        d.t1_walk = 1'b0;
        d.t2_walk = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/signal_monitor_if.sv
// Controller-to-monitor bundle: controller indications in, lamp drives and fault status out.
interface signal_monitor_if;
    import signal_monitor_pkg::*;

    logic [LAMP_W-1:0] T1;
    logic [LAMP_W-1:0] T2;
    logic              T1Walk;
    logic              T2Walk;
    logic              fault_clear;
    logic [LAMP_W-1:0] T1Lamp;
    logic [LAMP_W-1:0] T2Lamp;
    logic              T1WalkLamp;
    logic              T2WalkLamp;
    logic              fault;
    logic [CODE_W-1:0] fault_code;
    logic [CNT_W-1:0]  fault_count;

    modport master (
        output T1, T2, T1Walk, T2Walk, fault_clear,
        input  T1Lamp, T2Lamp, T1WalkLamp, T2WalkLamp, fault, fault_code, fault_count
    );

    modport slave (
        input  T1, T2, T1Walk, T2Walk, fault_clear,
        output T1Lamp, T2Lamp, T1WalkLamp, T2WalkLamp, fault, fault_code, fault_count
    );

endinterface

// File: rtl/signal_monitor_yellow_tracker.sv
// Per-head history: previous colour and consecutive-yellow count, flags entry to red without enough yellow.
module signal_monitor_yellow_tracker
    import signal_monitor_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = DEF_MIN_YELLOW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LAMP_W-1:0] color,
    output logic              short_yellow_c
);

    logic [LAMP_W-1:0] prev_color;
    logic [CNT_W-1:0]  yellow_cnt;

    // Tracks the head every cycle regardless of monitor state, so it is always in step with the inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_color <= LAMP_RED;
            yellow_cnt <= '0;
        end else begin
            prev_color <= color;
            if (color == LAMP_YEL) begin
                if (yellow_cnt != '1) begin
                    yellow_cnt <= yellow_cnt + CNT_W'(1);
                end
            end else begin
                yellow_cnt <= '0;
            end
        end
    end

    always_comb begin
        short_yellow_c = (color == LAMP_RED) &&
                         ((prev_color == LAMP_GRN) ||
                          ((prev_color == LAMP_YEL) && (yellow_cnt < CNT_W'(MIN_YELLOW))));
    end

endmodule

// File: rtl/signal_monitor.sv
// Conflict monitor: passes legal indications through one register stage, latches faults and flashes red.
module signal_monitor
    import signal_monitor_pkg::*;
#(
    parameter int unsigned FAULT_FILTER   = DEF_FAULT_FILTER,
    parameter int unsigned MIN_YELLOW     = DEF_MIN_YELLOW,
    parameter int unsigned FLASH_HALF     = DEF_FLASH_HALF,
    parameter int unsigned STARTUP_CYCLES = DEF_STARTUP_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    signal_monitor_if.slave bus
);

    state_t            state;
    logic              flash_on;
    logic [CNT_W-1:0]  half_cnt;
    logic [CNT_W-1:0]  startup_cnt;
    logic [CNT_W-1:0]  filt_cnt;
    lamp_drive_t       drive;
    logic              fault_q;
    logic [CODE_W-1:0] fault_code_q;
    logic [CNT_W-1:0]  fault_count_q;

    logic              short_yel_t1_c;
    logic              short_yel_t2_c;
    logic              raw_conflict_c;
    logic              raw_invalid_c;
    logic              raw_walk_c;
    logic              raw_level_c;
    logic              short_yel_c;
    logic [CNT_W-1:0]  filt_nxt_c;
    logic              level_trip_c;
    logic [CODE_W-1:0] cause_c;
    logic              flash_wrap_c;
    logic              flash_on_nxt_c;
    logic [CNT_W-1:0]  half_nxt_c;
    lamp_drive_t       in_drive_c;

    signal_monitor_yellow_tracker #(.MIN_YELLOW(MIN_YELLOW)) u_yellow_t1 (
        .clk            (clk),
        .reset          (reset),
        .color          (bus.T1),
        .short_yellow_c (short_yel_t1_c)
    );

    signal_monitor_yellow_tracker #(.MIN_YELLOW(MIN_YELLOW)) u_yellow_t2 (
        .clk            (clk),
        .reset          (reset),
        .color          (bus.T2),
        .short_yellow_c (short_yel_t2_c)
    );

    // Raw violation detection, filter advance and flash sequencing on the sampled inputs
    always_comb begin
        raw_conflict_c = (bus.T1 != LAMP_RED) && (bus.T2 != LAMP_RED);
        raw_invalid_c  = !lamp_legal(bus.T1) || !lamp_legal(bus.T2);
        raw_walk_c     = (bus.T1Walk && (bus.T1 != LAMP_RED)) ||
                         (bus.T2Walk && (bus.T2 != LAMP_RED));
        raw_level_c    = raw_conflict_c || raw_invalid_c || raw_walk_c;
        short_yel_c    = short_yel_t1_c || short_yel_t2_c;

        filt_nxt_c = '0;
        if (raw_level_c) begin
            filt_nxt_c = (filt_cnt == '1) ? filt_cnt : filt_cnt + CNT_W'(1);
        end
        level_trip_c = raw_level_c && (filt_nxt_c >= CNT_W'(FAULT_FILTER));

        cause_c = FC_NONE;
        if (raw_conflict_c) begin
            cause_c = FC_CONFLICT;
        end else if (raw_invalid_c) begin
            cause_c = FC_INVALID;
        end else if (raw_walk_c) begin
            cause_c = FC_WALK;
        end else if (short_yel_c) begin
            cause_c = FC_SHORT_YEL;
        end

        flash_wrap_c   = (half_cnt >= CNT_W'(FLASH_HALF - 1));
        flash_on_nxt_c = flash_wrap_c ? !flash_on : flash_on;
        half_nxt_c     = flash_wrap_c ? '0 : half_cnt + CNT_W'(1);

        in_drive_c.t1_lamp = bus.T1;
        in_drive_c.t2_lamp = bus.T2;
        in_drive_c.t1_walk = bus.T1Walk;
        in_drive_c.t2_walk = bus.T2Walk;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_STARTUP;
            flash_on      <= 1'b1;
            half_cnt      <= '0;
            startup_cnt   <= '0;
            filt_cnt      <= '0;
            drive         <= flash_drive(1'b1);
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
            fault_count_q <= '0;
        end else begin
            case (state)
                ST_STARTUP: begin
                    flash_on <= flash_on_nxt_c;
                    half_cnt <= half_nxt_c;
                    drive    <= flash_drive(flash_on_nxt_c);
                    filt_cnt <= '0;
                    if (startup_cnt >= CNT_W'(STARTUP_CYCLES - 1)) begin
                        state       <= ST_MONITOR;
                        startup_cnt <= '0;
                    end else begin
                        startup_cnt <= startup_cnt + CNT_W'(1);
                    end
                end

                ST_MONITOR: begin
                    if (level_trip_c || short_yel_c) begin
                        state        <= ST_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= cause_c;
                        if (fault_count_q != '1) begin
                            fault_count_q <= fault_count_q + CNT_W'(1);
                        end
                        flash_on <= 1'b1;
                        half_cnt <= '0;
                        drive    <= flash_drive(1'b1);
                        filt_cnt <= '0;
                    end else begin
                        filt_cnt <= filt_nxt_c;
                        drive    <= in_drive_c;
                    end
                end

                ST_FAULT: begin
                    // A clear request is honoured only once the level violations are gone
                    if (bus.fault_clear && !raw_level_c) begin
                        state        <= ST_MONITOR;
                        fault_q      <= 1'b0;
                        fault_code_q <= FC_NONE;
                        filt_cnt     <= '0;
                        drive        <= in_drive_c;
                    end else begin
                        flash_on <= flash_on_nxt_c;
                        half_cnt <= half_nxt_c;
                        drive    <= flash_drive(flash_on_nxt_c);
                    end
                end

                default: begin
                    state <= ST_STARTUP;
                end
            endcase
        end
    end

    assign bus.T1Lamp      = drive.t1_lamp;
    assign bus.T2Lamp      = drive.t2_lamp;
    assign bus.T1WalkLamp  = drive.t1_walk;
    assign bus.T2WalkLamp  = drive.t2_walk;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fault_code_q;
    assign bus.fault_count = fault_count_q;

endmodule

// File: tb/tb_signal_monitor.sv
// Directed-vector bench for signal_monitor with hand-computed expected lamp and fault values.
module tb_signal_monitor;
    import signal_monitor_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int unsigned n_compared = 0;
    int unsigned n_mismatch = 0;

    signal_monitor_if bus();

    signal_monitor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] t1, input logic [2:0] t2, input logic w1, input logic w2);
        bus.T1     = t1;
        bus.T2     = t2;
        bus.T1Walk = w1;
        bus.T2Walk = w2;
    endtask

    task automatic check_out(input string tag, input logic [2:0] l1, input logic [2:0] l2,
                             input logic wl1, input logic wl2, input logic f,
                             input logic [2:0] fc, input logic [7:0] cnt);
        check({tag, "/t1lamp"}, 32'(bus.T1Lamp), 32'(l1));
        check({tag, "/t2lamp"}, 32'(bus.T2Lamp), 32'(l2));
        check({tag, "/t1walk"}, 32'(bus.T1WalkLamp), 32'(wl1));
        check({tag, "/t2walk"}, 32'(bus.T2WalkLamp), 32'(wl2));
        check({tag, "/fault"}, 32'(bus.fault), 32'(f));
        check({tag, "/code"}, 32'(bus.fault_code), 32'(fc));
        check({tag, "/count"}, 32'(bus.fault_count), 32'(cnt));
    endtask

    // Reset, then run the four startup cycles so the monitor is live with both heads red
    task automatic restart();
        reset = 1'b1;
        set_in(3'b100, 3'b100, 1'b0, 1'b0);
        bus.fault_clear = 1'b0;
        step();
        reset = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        reset = 1'b1;
        set_in(3'b100, 3'b100, 1'b0, 1'b0);
        bus.fault_clear = 1'b0;
        #2;
        check_out("rst", 3'b100, 3'b100, 0, 0, 0, 3'd0, 8'd0);
        step();
        reset = 1'b0;
        check_out("rst_rel", 3'b100, 3'b100, 0, 0, 0, 3'd0, 8'd0);

        // Startup flash: OFF, ON, OFF, ON; walks held dark even when requested
        set_in(3'b100, 3'b100, 1'b1, 1'b1);
        step(); check_out("su1", 3'b000, 3'b000, 0, 0, 0, 3'd0, 8'd0);
        step(); check_out("su2", 3'b100, 3'b100, 0, 0, 0, 3'd0, 8'd0);
        step(); check_out("su3", 3'b000, 3'b000, 0, 0, 0, 3'd0, 8'd0);
        set_in(3'b100, 3'b100, 1'b0, 1'b0);
        step(); check_out("su4", 3'b100, 3'b100, 0, 0, 0, 3'd0, 8'd0);

        set_in(3'b001, 3'b100, 1'b0, 1'b0);
        step(); check_out("mon_first", 3'b001, 3'b100, 0, 0, 0, 3'd0, 8'd0);

        // Legal sequence: green -> yellow x2 -> red, then road 2 green
        set_in(3'b010, 3'b100, 1'b0, 1'b0);
        step(); check_out("leg_y1", 3'b010, 3'b100, 0, 0, 0, 3'd0, 8'd0);
        step(); check_out("leg_y2", 3'b010, 3'b100, 0, 0, 0, 3'd0, 8'd0);
        set_in(3'b100, 3'b100, 1'b0, 1'b0);
        step(); check_out("leg_r", 3'b100, 3'b100, 0, 0, 0, 3'd0, 8'd0);
        set_in(3'b100, 3'b001, 1'b0, 1'b0);
        step(); check_out("leg_t2g", 3'b100, 3'b001, 0, 0, 0, 3'd0, 8'd0);
        set_in(3'b100, 3'b001, 1'b1, 1'b0);
        step(); check_out("leg_walk", 3'b100, 3'b001, 1, 0, 0, 3'd0, 8'd0);

        // Conflict: one cycle is filtered, two cycles latch code 1
        restart();
        set_in(3'b001, 3'b001, 1'b0, 1'b0);
        step(); check_out("cf1", 3'b001, 3'b001, 0, 0, 0, 3'd0, 8'd0);
        step(); check_out("cf2", 3'b100, 3'b100, 0, 0, 1, 3'd1, 8'd1);
        step(); check_out("cf_flash", 3'b000, 3'b000, 0, 0, 1, 3'd1, 8'd1);
        bus.fault_clear = 1'b1;
        step(); check_out("clr_blocked", 3'b100, 3'b100, 0, 0, 1, 3'd1, 8'd1);
        bus.fault_clear = 1'b0;
        set_in(3'b100, 3'b001, 1'b0, 1'b0);
        step(); check_out("flt_ignore_in", 3'b000, 3'b000, 0, 0, 1, 3'd1, 8'd1);
        bus.fault_clear = 1'b1;
        step(); check("clr_ok/fault", 32'(bus.fault), 32'd0);
        check("clr_ok/code", 32'(bus.fault_code), 32'd0);
        check("clr_ok/count", 32'(bus.fault_count), 32'd1);
        bus.fault_clear = 1'b0;
        step(); check_out("post_clr", 3'b100, 3'b001, 0, 0, 0, 3'd0, 8'd1);
        set_in(3'b001, 3'b001, 1'b0, 1'b0);
        step(); step(); check_out("refault", 3'b100, 3'b100, 0, 0, 1, 3'd1, 8'd2);
        #2 reset = 1'b1;
        #1 check_out("mid_rst", 3'b100, 3'b100, 0, 0, 0, 3'd0, 8'd0);

        // Green straight to red: immediate short-yellow fault
        restart();
        set_in(3'b001, 3'b100, 1'b0, 1'b0);
        step(); check_out("sy_g", 3'b001, 3'b100, 0, 0, 0, 3'd0, 8'd0);
        set_in(3'b100, 3'b100, 1'b0, 1'b0);
        step(); check_out("sy_g2r", 3'b100, 3'b100, 0, 0, 1, 3'd4, 8'd1);

        // One yellow cycle is shorter than the minimum
        restart();
        set_in(3'b001, 3'b100, 1'b0, 1'b0);
        step();
        set_in(3'b010, 3'b100, 1'b0, 1'b0);
        step(); check("sy1_y/fault", 32'(bus.fault), 32'd0);
        set_in(3'b100, 3'b100, 1'b0, 1'b0);
        step(); check_out("sy1_r", 3'b100, 3'b100, 0, 0, 1, 3'd4, 8'd1);

        // Invalid code 011
        restart();
        set_in(3'b011, 3'b100, 1'b0, 1'b0);
        step(); check_out("inv1", 3'b011, 3'b100, 0, 0, 0, 3'd0, 8'd0);
        step(); check_out("inv2", 3'b100, 3'b100, 0, 0, 1, 3'd2, 8'd1);

        // Walk against green
        restart();
        set_in(3'b001, 3'b100, 1'b1, 1'b0);
        step(); check_out("wk1", 3'b001, 3'b100, 1, 0, 0, 3'd0, 8'd0);
        step(); check_out("wk2", 3'b100, 3'b100, 0, 0, 1, 3'd3, 8'd1);

        // Conflict and invalid together: lowest code wins, count steps once
        restart();
        set_in(3'b001, 3'b111, 1'b0, 1'b0);
        step();
        step(); check_out("simul", 3'b100, 3'b100, 0, 0, 1, 3'd1, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/signal_monitor.md
Name: signal_monitor

Overview:
- Conflict monitor between trafficController outputs (T1, T2, T1Walk, T2Walk) and the physical lamp heads.
- Passes legal indications through with one cycle of registering.
- Detects illegal or conflicting indications, latches a fault, and forces both heads to flashing red with walks dark until the fault is cleared.
- Lamp encoding, fixed for the whole design: bit2 = red, bit1 = yellow, bit0 = green. The only legal codes are 100, 010 and 001.

Parameters:
- FAULT_FILTER, 2: consecutive cycles a level-type violation must persist before it latches a fault.
- MIN_YELLOW, 2: minimum number of yellow cycles before a head may enter red.
- FLASH_HALF, 1: length of each half-period of flashing red, in cycles.
- STARTUP_CYCLES, 4: length of the flash period after reset, in cycles.

Ports:
- clk, input, 1: system clock (1 Hz in system).
- reset, input, 1: asynchronous, active-high reset.
- T1, input, 3: controller lamp code, road 1.
- T2, input, 3: controller lamp code, road 2.
- T1Walk, input, 1: controller walk request, crossing of road 1.
- T2Walk, input, 1: controller walk request, crossing of road 2.
- fault_clear, input, 1: synchronous request to leave the fault state.
- T1Lamp, output, 3: lamp drive, road 1.
- T2Lamp, output, 3: lamp drive, road 2.
- T1WalkLamp, output, 1: walk lamp drive, road 1 crossing.
- T2WalkLamp, output, 1: walk lamp drive, road 2 crossing.
- fault, output, 1: fault latched.
- fault_code, output, 3: cause of the latched fault; 0 when there is no fault.
- fault_count, output, 8: number of faults latched since reset; saturates at 255.

Behaviour:
- Reset (asynchronous, any time, including mid-fault):
  - State goes to STARTUP; flash phase is ON.
  - T1Lamp = T2Lamp = 100; both walk lamps 0.
  - fault = 0, fault_code = 0, fault_count = 0; all internal counters = 0.
- STARTUP:
  - Lamps flash red. Phase is ON (100) for FLASH_HALF cycles, then OFF (000) for FLASH_HALF cycles, repeating. Walk lamps are 0.
  - No checks are performed. prev_color registers track the T1/T2 inputs every cycle.
  - After STARTUP_CYCLES cycles, go to MONITOR.
- MONITOR:
  - All outputs are registered copies of the inputs, so latency is one cycle.
  - Checks are evaluated every posedge on the sampled inputs.
  - Code 1, conflict: T1 != 100 and T2 != 100. Filtered.
  - Code 2, invalid: T1 or T2 is not one of {100, 010, 001}. Filtered.
  - Code 3, walk conflict: (T1Walk and T1 != 100) or (T2Walk and T2 != 100). Filtered.
  - Code 4, short yellow: a head enters 100 when its prev_color was 001, or when it was 010 with yellow_cnt < MIN_YELLOW. Immediate, no filter.
- Filtering:
  - A single filter counter increments while any of codes 1–3 is active and clears to 0 when none is active.
  - The fault latches on the edge where the counter reaches FAULT_FILTER.
- Per-head yellow tracking:
  - yellow_cnt (8-bit, saturating) increments while the head is 010.
  - yellow_cnt clears on any other code.
  - prev_color updates every cycle.
- Fault latch:
  - On the latching edge: state goes to FAULT; fault = 1; fault_code takes the lowest-numbered active cause; fault_count increments (saturating at 255).
  - On the same edge, lamps take the flash ON value (100/100) and walks go to 0.
- FAULT:
  - Flash red exactly as in STARTUP; walks 0. The inputs are ignored for outputs.
  - If fault_clear = 1 and no raw code 1–3 condition is present on that cycle, go to MONITOR on the next edge: fault = 0, fault_code = 0, filter counter = 0, yellow trackers resynchronised to the inputs.
  - fault_count is retained until reset.
  - If fault_clear = 1 while a violation is still present, the request is ignored and the state stays FAULT.
- Simultaneous causes: fault_code is the lowest-numbered cause; fault_count increments by exactly 1.

Decomposition:
- Shared package holds:
  - lamp code constants LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001, LAMP_OFF = 3'b000;
  - fault code constants 0–4;
  - state encoding STARTUP / MONITOR / FAULT.
- One sub-module, yellow_tracker, instantiated once per head. It holds prev_color and yellow_cnt and outputs a short_yellow pulse.

Test Plan:
- Reset then 4 cycles: lamps toggle 100/000 with FLASH_HALF = 1. At cycle 5 the state is MONITOR; an input of T1=001, T2=100 appears on the lamps one cycle later; fault = 0.
- Legal sequence T1: 001 → 010 held 2 cycles → 100, then T2: 100 → 001. No fault; outputs track the inputs with 1-cycle latency.
- T1=001, T2=001:
  - held 1 cycle: no fault;
  - held 2 cycles: fault = 1, fault_code = 1, fault_count = 1, lamps flash red, walks 0.
- T1 goes 001 → 100 with no yellow: fault_code = 4 on the next edge.
- T1=011 and T1Walk=1 with T1=001 on separate runs, each held 2 cycles: fault_code = 2 and fault_code = 3 respectively.
- Fault clear and reset:
  - In FAULT with the conflict still present, pulse fault_clear: remains in FAULT.
  - Remove the conflict, then pulse fault_clear: MONITOR, fault = 0, fault_count keeps its value (1).
  - Assert reset mid-fault: immediate STARTUP, fault_count = 0.
